mips_cpu_muldiv: RTL and testbench
==================================

# mips_cpu_muldiv

Parametrised iterative multiply/divide unit that owns the HI/LO register pair for the multi-cycle MIPS core. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. The core starts an operation with a one-cycle `start` strobe and stalls on `busy` before any MFHI/MFLO. Width and the number of radix-2 steps per cycle are configurable, and signed divide follows MIPS truncation semantics.

## Interface

- `WIDTH`, 32: operand and HI/LO width. Must be even and ≥ 8.
- `STEPS_PER_CYCLE`, 1: radix-2 iterations performed per clock. Must divide `WIDTH`. N = WIDTH/STEPS_PER_CYCLE.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `clk_enable`  in  1  when low, all registers hold and the strobe is ignored.
- `start`  in  1  operation strobe, sampled at a rising edge with `clk_enable` high.
- `op`  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO; 110/111 reserved.
- `a`  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- `b`  in  WIDTH  rt operand: multiplier or divisor.
- `busy`  out  1  high while a mult/div is in flight.
- `done`  out  1  one-enabled-cycle pulse after HI/LO take a mult/div result.
- `div_by_zero`  out  1  valid while `done` is high; set for a divide with b == 0.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation

- **States:** IDLE and RUN. A step counter runs 0..N-1.
- **IDLE, start with op 000–011:** latch operand magnitudes.
  - Signed ops take the two's-complement absolute value of each operand.
  - Record the result sign and remainder sign.
  - Clear the accumulator and counter, then go to RUN.
- **IDLE, start with op 100/101:** write `a` to HI or LO at that edge. No busy, no done.
- **IDLE, start with op 110/111:** ignored.
- **RUN, multiply:** shift-add, STEPS_PER_CYCLE multiplier bits per cycle, into a 2·WIDTH product.
- **RUN, divide:** restoring division, STEPS_PER_CYCLE quotient bits per cycle.
- **Final step (counter == N-1):**
  - Apply the sign fix and write HI/LO.
  - Assert `done` and return to IDLE.
- **Results:**
  - Multiply: HI = product[2W-1:W], LO = product[W-1:0].
  - Divide: LO = quotient, truncated toward zero. HI = remainder, carrying the dividend's sign.
  - The product/quotient is negated iff the operand signs differ (signed ops only).
- **DIV most-negative / -1:** LO = 1 followed by W-1 zeros (the magnitude wraps), HI = 0.
- **Divide by zero (DIV or DIVU):** LO = all ones, HI = `a` unchanged, `div_by_zero` = 1 with `done`.
- **While RUN:**
  - `start` of any op is ignored, including MTHI/MTLO.
  - HI/LO hold their previous values.
- **Mid-operation `rst`:** aborts the operation. Next state is IDLE; HI, LO, `busy`, `done` and `div_by_zero` are all 0.

## Timing

- **Reset values:** `busy` = 0, `done` = 0, `div_by_zero` = 0, `hi` = 0, `lo` = 0, state IDLE.
- **Latency:** start accepted at enabled edge k. `busy` is high from after edge k through edge k+N. HI/LO update at enabled edge k+N.
  - `done` is high for the cycle after edge k+N, until the next enabled edge.
- **Back-to-back starts:** a `start` presented while `done` is high is accepted, since the state is already IDLE. This gives back-to-back operations every N cycles.
- **Stalls:** `clk_enable` low stretches every phase by the number of disabled cycles. `done` and `busy` hold their values while disabled.
- **MTHI/MTLO:** HI/LO visible the cycle after the accepting edge.
- **Width rules:** the counter is $clog2(N) bits and must not wrap past N-1. All intermediate sums use WIDTH+1 bits so no carry is lost.

## Test plan

- **MULTU (WIDTH 32, STEPS 1):** a = 0xFFFFFFFF, b = 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001. `done` exactly 32 cycles after accept; `busy` high for 32 cycles.
- **MULT:** a = -3, b = 7 → hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
  - Then a back-to-back start on the `done` cycle, MULT 0x7FFFFFFF × 2 → hi = 0, lo = 0xFFFFFFFE.
- **DIV:** -7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - DIVU 7 / 2 → lo = 3, hi = 1.
  - DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- **Divide by zero:** DIVU 5 / 0 → lo = 0xFFFFFFFF, hi = 5, `div_by_zero` = 1 with `done`.
  - A following DIVU 9 / 3 → `div_by_zero` = 0, lo = 3, hi = 0.
- **MTHI/MTLO:** MTHI 0x1234 then MTLO 0x5678 on consecutive cycles → hi = 0x1234, lo = 0x5678, no `done`.
  - MTHI issued during a running MULT is ignored; hi equals the MULT result.
- **Reset, enable and parametrisation:**
  - `rst` at step 10 of a DIV → hi = lo = 0, `busy` = 0 next cycle.
  - `clk_enable` low for 5 cycles mid-MULT → `done` arrives 37 cycles after accept.
  - WIDTH = 16, STEPS = 4: MULT -2 × 3 → hi = 0xFFFF, lo = 0xFFFA, `done` 4 cycles after accept.

Source files
------------

// File: rtl/mips_cpu_muldiv_if.sv
// Purpose: request/response bundle between the MIPS core and the HI/LO
//          multiply/divide unit.
// Signals:
//   clk_enable  core -> unit  global advance enable
//   start       core -> unit  one-cycle operation strobe
//   op          core -> unit  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO
//   a, b        core -> unit  rs / rt operands
//   busy        unit -> core  mult/div in flight
//   done        unit -> core  HI/LO just took a mult/div result
//   div_by_zero unit -> core  qualifies done for a divide by zero
//   hi, lo      unit -> core  HI/LO registers
interface mips_cpu_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             clk_enable;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output clk_enable, start, op, a, b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  clk_enable, start, op, a, b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mips_cpu_muldiv.sv
// Purpose: iterative radix-2 multiply/divide unit owning HI/LO for the
//          multi-cycle MIPS core (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  mips_cpu_muldiv_if.slave (enable, strobe, op, operands, status, HI/LO)
// Parameters:
//   WIDTH            operand and HI/LO width (even, >= 8)
//   STEPS_PER_CYCLE  radix-2 iterations per clock (divides WIDTH)
module mips_cpu_muldiv #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  mips_cpu_muldiv_if.slave  bus
);

  localparam int unsigned N      = WIDTH / STEPS_PER_CYCLE;
  localparam int unsigned CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Multiply: opb = multiplicand, acc_hi = partial product, acc_lo = multiplier/low product.
  // Divide:   opb = divisor, acc_hi = partial remainder, acc_lo = dividend/quotient.
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dbz_flag_q, dbz_flag_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  // Datapath temporaries
  logic               signed_op;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic               q_bit;
  logic [2*WIDTH-1:0] prod;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      opb_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_flag_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opb_q      <= opb_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dbz_flag_q <= dbz_flag_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opb_d      = opb_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dbz_flag_d = dbz_flag_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = done_q;
    dbz_d      = dbz_q;

    signed_op = bus.op[0];
    a_abs     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_abs     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    step_hi   = acc_hi_q;
    step_lo   = acc_lo_q;
    sum       = '0;
    shifted   = '0;
    q_bit     = 1'b0;
    prod      = '0;

    if (bus.clk_enable) begin
      // done/div_by_zero are single enabled-cycle pulses
      done_d = 1'b0;
      dbz_d  = 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            unique case (bus.op)
              OP_MULTU, OP_MULT: begin
                opb_d      = a_abs;
                acc_hi_d   = '0;
                acc_lo_d   = b_abs;
                is_div_d   = 1'b0;
                neg_res_d  = signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_rem_d  = 1'b0;
                dbz_flag_d = 1'b0;
                cnt_d      = '0;
                busy_d     = 1'b1;
                state_d    = S_RUN;
              end
              OP_DIVU, OP_DIV: begin
                opb_d      = b_abs;
                acc_hi_d   = '0;
                acc_lo_d   = a_abs;
                is_div_d   = 1'b1;
                neg_res_d  = signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_rem_d  = signed_op & bus.a[WIDTH-1];
                dbz_flag_d = (bus.b == '0);
                cnt_d      = '0;
                busy_d     = 1'b1;
                state_d    = S_RUN;
              end
              OP_MTHI: hi_d = bus.a;
              OP_MTLO: lo_d = bus.a;
              default: ;
            endcase
          end
        end

        S_RUN: begin
          for (int s = 0; s < int'(STEPS_PER_CYCLE); s++) begin
            if (is_div_q) begin
              // Restoring step: shift in next dividend bit, subtract if it fits
              shifted = {step_hi, step_lo[WIDTH-1]};
              q_bit   = (shifted >= {1'b0, opb_q});
              step_hi = q_bit ? (shifted[WIDTH-1:0] - opb_q) : shifted[WIDTH-1:0];
              step_lo = {step_lo[WIDTH-2:0], q_bit};
            end else begin
              // Shift-add step: carry out of the add lands in the shifted product
              sum     = {1'b0, step_hi} + (step_lo[0] ? {1'b0, opb_q} : '0);
              step_lo = {sum[0], step_lo[WIDTH-1:1]};
              step_hi = sum[WIDTH:1];
            end
          end
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;

          if (cnt_q == CNT_LAST) begin
            if (is_div_q) begin
              lo_d = dbz_flag_q ? '1 : (neg_res_q ? -step_lo : step_lo);
              // Divide by zero leaves |a| in the remainder, so the sign fix restores a
              hi_d = neg_rem_q ? -step_hi : step_hi;
            end else begin
              prod = {step_hi, step_lo};
              if (neg_res_q) prod = -prod;
              hi_d = prod[2*WIDTH-1:WIDTH];
              lo_d = prod[WIDTH-1:0];
            end
            dbz_d   = dbz_flag_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Purpose: directed self-checking bench for mips_cpu_muldiv (32-bit/1-step
//          and 16-bit/4-step instances).
module tb_mips_cpu_muldiv;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   lat;
  int   busy_cnt;

  mips_cpu_muldiv_if #(.WIDTH(32)) bus32 ();
  mips_cpu_muldiv_if #(.WIDTH(16)) bus16 ();

  mips_cpu_muldiv #(.WIDTH(32), .STEPS_PER_CYCLE(1)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32.slave)
  );

  mips_cpu_muldiv #(.WIDTH(16), .STEPS_PER_CYCLE(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a one-cycle strobe on the 32-bit unit
  task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus32.start = 1'b1;
    bus32.op    = op;
    bus32.a     = a;
    bus32.b     = b;
    tick();
    bus32.start = 1'b0;
  endtask

  // Cycles from the accepting edge until done is seen; busy samples counted alongside
  task automatic wait_done32(output int cycles, output int busy_n);
    cycles = 0;
    busy_n = (bus32.busy === 1'b1) ? 1 : 0;
    while (bus32.done !== 1'b1 && cycles < 100) begin
      tick();
      cycles++;
      if (bus32.busy === 1'b1) busy_n++;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus32.clk_enable = 1'b1; bus32.start = 1'b0; bus32.op = 3'b000; bus32.a = '0; bus32.b = '0;
    bus16.clk_enable = 1'b1; bus16.start = 1'b0; bus16.op = 3'b000; bus16.a = '0; bus16.b = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_busy", 64'(bus32.busy), 64'd0);
    chk("rst_done", 64'(bus32.done), 64'd0);
    chk("rst_dbz",  64'(bus32.div_by_zero), 64'd0);
    chk("rst_hilo", {bus32.hi, bus32.lo}, 64'h0);

    // MULTU max * max, latency and busy window
    issue32(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done32(lat, busy_cnt);
    chk("multu_lat",  64'(lat), 64'd32);
    chk("multu_busy", 64'(busy_cnt), 64'd32);
    chk("multu_hilo", {bus32.hi, bus32.lo}, 64'hFFFF_FFFE_0000_0001);
    chk("multu_dbz",  64'(bus32.div_by_zero), 64'd0);

    // MULT -3 * 7 then back-to-back start on the done cycle
    issue32(3'b001, 32'hFFFF_FFFD, 32'd7);
    wait_done32(lat, busy_cnt);
    chk("mult_hilo", {bus32.hi, bus32.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mult_done_for_b2b", 64'(bus32.done), 64'd1);
    issue32(3'b001, 32'h7FFF_FFFF, 32'd2);
    chk("b2b_busy", 64'(bus32.busy), 64'd1);
    wait_done32(lat, busy_cnt);
    chk("b2b_lat",  64'(lat), 64'd32);
    chk("b2b_hilo", {bus32.hi, bus32.lo}, 64'h0000_0000_FFFF_FFFE);

    // Signed and unsigned divide
    issue32(3'b011, 32'hFFFF_FFF9, 32'd2);
    wait_done32(lat, busy_cnt);
    chk("div_neg_hilo", {bus32.hi, bus32.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue32(3'b010, 32'd7, 32'd2);
    wait_done32(lat, busy_cnt);
    chk("divu_hilo", {bus32.hi, bus32.lo}, 64'h0000_0001_0000_0003);
    issue32(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done32(lat, busy_cnt);
    chk("div_minneg_hilo", {bus32.hi, bus32.lo}, 64'h0000_0000_8000_0000);

    // Divide by zero then a clean divide
    issue32(3'b010, 32'd5, 32'd0);
    wait_done32(lat, busy_cnt);
    chk("dbz_flag", 64'(bus32.div_by_zero), 64'd1);
    chk("dbz_hilo", {bus32.hi, bus32.lo}, 64'h0000_0005_FFFF_FFFF);
    issue32(3'b010, 32'd9, 32'd3);
    wait_done32(lat, busy_cnt);
    chk("after_dbz_flag", 64'(bus32.div_by_zero), 64'd0);
    chk("after_dbz_hilo", {bus32.hi, bus32.lo}, 64'h0000_0000_0000_0003);
    tick();
    chk("done_drops", 64'(bus32.done), 64'd0);

    // MTHI then MTLO on consecutive cycles
    bus32.start = 1'b1; bus32.op = 3'b100; bus32.a = 32'h1234;
    tick();
    chk("mthi_hi", 64'(bus32.hi), 64'h1234);
    bus32.op = 3'b101; bus32.a = 32'h5678;
    tick();
    bus32.start = 1'b0;
    chk("mtlo_hilo", {bus32.hi, bus32.lo}, 64'h0000_1234_0000_5678);
    chk("mt_no_done", 64'(bus32.done), 64'd0);
    chk("mt_no_busy", 64'(bus32.busy), 64'd0);

    // MTHI during a running MULT is dropped
    issue32(3'b001, 32'h0001_2345, 32'h0001_0000);
    tick(); tick(); tick();
    bus32.start = 1'b1; bus32.op = 3'b100; bus32.a = 32'hAAAA_AAAA;
    tick();
    bus32.start = 1'b0;
    chk("mthi_run_hi_held", 64'(bus32.hi), 64'h1234);
    wait_done32(lat, busy_cnt);
    chk("mthi_run_lat", 64'(lat), 64'd28);
    chk("mthi_run_hilo", {bus32.hi, bus32.lo}, 64'h0000_0001_2345_0000);

    // Reset ten steps into a DIV
    issue32(3'b011, 32'd100, 32'd7);
    for (int i = 0; i < 10; i++) tick();
    chk("pre_rst_busy", 64'(bus32.busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_hilo", {bus32.hi, bus32.lo}, 64'h0);
    chk("abort_busy", 64'(bus32.busy), 64'd0);
    chk("abort_done", 64'(bus32.done), 64'd0);

    // Five disabled cycles in the middle of a MULT
    issue32(3'b001, 32'd5, 32'd6);
    for (int i = 0; i < 10; i++) tick();
    bus32.clk_enable = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_busy_held", 64'(bus32.busy), 64'd1);
    bus32.clk_enable = 1'b1;
    wait_done32(lat, busy_cnt);
    chk("stall_lat", 64'(lat + 15), 64'd37);
    chk("stall_hilo", {bus32.hi, bus32.lo}, 64'h0000_0000_0000_001E);
    bus32.clk_enable = 1'b0;
    tick();
    chk("stall_done_held", 64'(bus32.done), 64'd1);
    bus32.clk_enable = 1'b1;

    // 16-bit, four steps per cycle: MULT -2 * 3
    bus16.start = 1'b1; bus16.op = 3'b001; bus16.a = 16'hFFFE; bus16.b = 16'd3;
    tick();
    bus16.start = 1'b0;
    lat = 0;
    while (bus16.done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    chk("w16_lat",  64'(lat), 64'd4);
    chk("w16_hilo", 64'({bus16.hi, bus16.lo}), 64'hFFFF_FFFA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
